// File: rtl/sint_eq_match_tracker_if.sv
// Handshake bundle for the signed-equality match tracker.
// eq_hist exists only when EQ_HISTORY_EN is defined.
interface sint_eq_match_tracker_if #(
    parameter int WIDTH = 3,
    parameter int RUN_W = 4
);
    logic signed [WIDTH-1:0] I0;
    logic signed [WIDTH-1:0] I1;
    logic                    in_valid;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_eq;
    logic [RUN_W-1:0]        out_run;
    logic                    locked;
`ifdef EQ_HISTORY_EN
    logic [7:0]              eq_hist;
`endif

    modport master (
        output I0, I1, in_valid, out_ready,
        input  in_ready, out_valid, out_eq, out_run, locked
`ifdef EQ_HISTORY_EN
        , eq_hist
`endif
    );

    modport slave (
        input  I0, I1, in_valid, out_ready,
        output in_ready, out_valid, out_eq, out_run, locked
`ifdef EQ_HISTORY_EN
        , eq_hist
`endif
    );
endinterface

// File: rtl/sint_eq_match_tracker.sv
// Registered equality stage with match run counter and lock FSM.
// Define EQ_HISTORY_EN to add the 8-bit eq_hist shift register.
module sint_eq_match_tracker #(
    parameter int WIDTH      = 3,
    parameter int RUN_W      = 4,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 2
) (
    input logic CLK,
    input logic ASYNCRESETN,
    sint_eq_match_tracker_if.slave bus
);
    localparam int MISS_W = $clog2(LOSS_COUNT + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX = '1;
    localparam logic [RUN_W-1:0]  LOCK_V  = RUN_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] LOSS_V  = MISS_W'(LOSS_COUNT);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [MISS_W-1:0] miss_q, miss_d, miss_inc;
    logic              out_valid_q, out_eq_q;
    logic              eq, accept, pop;

    // Ready is forced low while reset is held so nothing is taken in.
    assign bus.in_ready = ASYNCRESETN & (~out_valid_q | bus.out_ready);
    assign accept = bus.in_valid & bus.in_ready;
    assign pop = out_valid_q & bus.out_ready;

    always_comb begin
        eq = (bus.I0 == bus.I1);
        run_d = '0;
        state_d = state_q;
        miss_d = miss_q;
        miss_inc = miss_q + 1'b1;
        if (eq)
            run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
        unique case (state_q)
            SEARCH: begin
                if (eq && run_d >= LOCK_V) begin
                    state_d = LOCKED;
                    miss_d = '0;
                end
            end
            LOCKED: begin
                if (eq) begin
                    miss_d = '0;
                end else if (miss_inc == LOSS_V) begin
                    state_d = SEARCH;
                    miss_d = '0;
                end else begin
                    miss_d = miss_inc;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= SEARCH;
            run_q <= '0;
            miss_q <= '0;
            out_valid_q <= 1'b0;
            out_eq_q <= 1'b0;
        end else if (accept) begin
            state_q <= state_d;
            run_q <= run_d;
            miss_q <= miss_d;
            out_valid_q <= 1'b1;
            out_eq_q <= eq;
        end else if (pop) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_eq = out_eq_q;
    assign bus.out_run = run_q;
    assign bus.locked = (state_q == LOCKED);

`ifdef EQ_HISTORY_EN
    logic [7:0] hist_q;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN)
            hist_q <= '0;
        else if (accept)
            hist_q <= {hist_q[6:0], eq};
    end

    assign bus.eq_hist = hist_q;
`endif
endmodule
